// File: rtl/game_start_ctrl.sv
// ---------------------------------------------------------------------------
// game_start_ctrl
//
// Game-flow front end between the start switch (switch 8), the LCD screen
// mux and the game core. It synchronizes and debounces the raw switch,
// runs the pre-game countdown, fires a one-cycle start pulse into the game
// core and selects which screen the LCD drivers show.
//
// Parameters
//   DEB_CYCLES  consecutive stable synchronized samples needed to change
//               the debounced level (>= 2)
//   TICK_DIV    CLK cycles per countdown step (>= 2)
//   COUNT_FROM  countdown start value (1..9)
//
// Ports
//   CLK         system clock, all logic on the rising edge
//   RESETN      asynchronous active-low reset
//   SW_START    raw start switch, asynchronous to CLK, may bounce
//   GAME_OVER   one-cycle pulse from the game core, honoured only in PLAY
//   SW_LEVEL    debounced switch level
//   SCREEN_SEL  00 prompt, 01 countdown, 10 in-game, 11 game-over
//   COUNT_VAL   current countdown digit, binary
//   GAME_START  one-cycle pulse on entry to PLAY
//   GAME_EN     high throughout PLAY
// ---------------------------------------------------------------------------
module game_start_ctrl #(
  parameter int DEB_CYCLES = 20,
  parameter int TICK_DIV   = 1000,
  parameter int COUNT_FROM = 3
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       SW_START,
  input  logic       GAME_OVER,
  output logic       SW_LEVEL,
  output logic [1:0] SCREEN_SEL,
  output logic [3:0] COUNT_VAL,
  output logic       GAME_START,
  output logic       GAME_EN
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [3:0]    COUNT_INIT = 4'(COUNT_FROM);

  localparam logic [1:0] SCR_PROMPT = 2'b00;
  localparam logic [1:0] SCR_COUNT  = 2'b01;
  localparam logic [1:0] SCR_PLAY   = 2'b10;
  localparam logic [1:0] SCR_OVER   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    COUNTDOWN,
    PLAY,
    OVER
  } state_t;

  state_t          state;
  state_t          state_next;

  logic            s1;
  logic            s2;
  logic            v1;
  logic            v2;
  logic [DW-1:0]   deb_cnt;
  logic            lvl_q;
  logic            rise;
  logic            armed;
  logic            arm_clear;
  logic [PW-1:0]   presc;
  logic [PW-1:0]   presc_next;
  logic            tick;

  logic [1:0]      screen_next;
  logic [3:0]      count_next;
  logic            start_next;
  logic            en_next;

  // Two-flop synchronizer for the raw switch. v1/v2 travel alongside it and
  // mark the point where s2 holds a real post-reset sample of the switch
  // rather than its reset value.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      s1 <= SW_START;
      s2 <= s1;
      v1 <= 1'b1;
      v2 <= v1;
    end
  end

  // Debouncer: the level only flips after DEB_CYCLES consecutive samples
  // disagreeing with it; any agreeing sample restarts the count.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      deb_cnt  <= '0;
      SW_LEVEL <= 1'b0;
    end else if (s2 == SW_LEVEL) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      SW_LEVEL <= ~SW_LEVEL;
      deb_cnt  <= '0;
    end else begin
      deb_cnt <= deb_cnt + DW'(1);
    end
  end

  // Delayed copy of the debounced level for rising-edge detection.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= SW_LEVEL;
    end
  end

  assign rise = SW_LEVEL & ~lvl_q;

  // Armed flag: a game may only start after the switch has genuinely been
  // seen off. The debounced level is 0 straight out of reset even when the
  // switch is physically on, so arming also waits for a real synchronized
  // "off" sample. A switch held on through reset therefore has to be turned
  // off before it can start a game.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      armed <= 1'b0;
    end else if (arm_clear) begin
      armed <= 1'b0;
    end else if (!SW_LEVEL && !s2 && v2) begin
      armed <= 1'b1;
    end
  end

  assign tick = (state == COUNTDOWN) && (presc == TICK_LAST);

  // State and output registers. Every output is registered so the LCD mux
  // and game core see glitch-free signals that change with the state.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state      <= IDLE;
      presc      <= '0;
      SCREEN_SEL <= SCR_PROMPT;
      COUNT_VAL  <= 4'd0;
      GAME_START <= 1'b0;
      GAME_EN    <= 1'b0;
    end else begin
      state      <= state_next;
      presc      <= presc_next;
      SCREEN_SEL <= screen_next;
      COUNT_VAL  <= count_next;
      GAME_START <= start_next;
      GAME_EN    <= en_next;
    end
  end

  // Next-state and next-output logic. In COUNTDOWN the switch going off is
  // checked before the tick so an abort wins over a simultaneous tick; in
  // PLAY game-over is checked first so it wins over the switch going off.
  always_comb begin
    state_next  = state;
    presc_next  = presc;
    screen_next = SCREEN_SEL;
    count_next  = COUNT_VAL;
    start_next  = 1'b0;
    en_next     = GAME_EN;
    arm_clear   = 1'b0;

    case (state)
      IDLE: begin
        if (rise && armed) begin
          state_next  = COUNTDOWN;
          screen_next = SCR_COUNT;
          count_next  = COUNT_INIT;
          presc_next  = '0;
          arm_clear   = 1'b1;
        end
      end

      COUNTDOWN: begin
        if (!SW_LEVEL) begin
          state_next  = IDLE;
          screen_next = SCR_PROMPT;
          count_next  = 4'd0;
          presc_next  = '0;
        end else if (tick) begin
          presc_next = '0;
          if (COUNT_VAL > 4'd1) begin
            count_next = COUNT_VAL - 4'd1;
          end else begin
            state_next  = PLAY;
            screen_next = SCR_PLAY;
            count_next  = 4'd0;
            start_next  = 1'b1;
            en_next     = 1'b1;
          end
        end else begin
          presc_next = presc + PW'(1);
        end
      end

      PLAY: begin
        if (GAME_OVER) begin
          state_next  = OVER;
          screen_next = SCR_OVER;
          en_next     = 1'b0;
        end else if (!SW_LEVEL) begin
          state_next  = IDLE;
          screen_next = SCR_PROMPT;
          en_next     = 1'b0;
        end
      end

      OVER: begin
        if (!SW_LEVEL) begin
          state_next  = IDLE;
          screen_next = SCR_PROMPT;
        end
      end

      default: begin
        state_next  = IDLE;
        screen_next = SCR_PROMPT;
        count_next  = 4'd0;
        en_next     = 1'b0;
        presc_next  = '0;
      end
    endcase
  end

endmodule
